capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Acquisition sequencer between the ADC inputs and the three 512-entry sample RAMs.
- Generates adc_clk and the RAM strobes (rclk, en, we, addr) and decimates the sample stream.
- Runs the pre-trigger / trigger / post-trigger state machine and reports where the oldest sample sits.
- After capture it gives the RAM port to the command core for readout.

Parameters:
DEPTH, 512, sample RAM entries per channel
ADDR_W, 9, RAM address width (log2 DEPTH)
DEC_W, 4, width of decimation exponent

Ports:
clk  in  1  system clock (40 MHz)
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; arm a new capture
force_trig  in  1  one-cycle pulse; software trigger
trig1  in  1  async trigger from AFE channel 1
trig2  in  1  async trigger from AFE channel 2
trig_sel  in  1  0=trig1, 1=trig2
trig_edge  in  1  1=rising, 0=falling
trig_pos  in  ADDR_W  samples to store after trigger
dec_pwr  in  DEC_W  store one sample every 2^dec_pwr ADC samples
rd_en  in  1  readout request (honoured only in IDLE/DONE)
rd_addr  in  ADDR_W  readout address
adc_clk  out  1  clk/2 to ADCs
rclk  out  1  RAM clock = ~adc_clk
en  out  1  RAM enable
we  out  1  RAM write enable
addr  out  ADDR_W  RAM address
armed  out  1  high in ARMED
capture_done  out  1  high in DONE
oldest_addr  out  ADDR_W  address of oldest stored sample, valid when capture_done

Behaviour:
- Clock and reset:
  - Single clock domain. rst is synchronous and active-high.
  - Reset values: adc_clk=0, rclk=1, en=0, we=0, addr=0, armed=0, capture_done=0, oldest_addr=0. State=IDLE and all counters 0.
  - rst mid-capture aborts to IDLE on the next edge. RAM contents are don't-care.
- adc_clk toggles every clk cycle. The sample tick smp is the cycle with adc_clk==0, so the next edge raises adc_clk.
- Decimation:
  - 16-bit dec_cnt advances on smp.
  - cap_tick = smp && dec_cnt == 2^dec_pwr-1, after which dec_cnt clears.
  - dec_pwr=0 means every sample. dec_cnt clears on start.
- Trigger path:
  - trig1 and trig2 each pass through a 2-flop synchronizer, then trig_sel picks one.
  - Edge detect uses a third flop. trig_evt is a one-cycle pulse per qualified edge, 3-4 cycles after the pin changes.
  - force_trig ORs into trig_evt.
- FSM:
  - IDLE: start -> PRE. Clear wr_ptr, pre_cnt, post_cnt.
  - PRE: on each cap_tick write wr_ptr, wr_ptr++ (wraps DEPTH-1 -> 0), pre_cnt++. When pre_cnt == DEPTH-trig_pos -> ARMED. trig_evt in PRE is ignored.
  - ARMED: continue writing and wrapping. trig_evt -> POST (or DONE directly if trig_pos==0).
  - POST: write on cap_tick, post_cnt++. When post_cnt == trig_pos -> DONE.
  - DONE: capture_done=1, oldest_addr=wr_ptr (next write slot = oldest sample).
  - start in any non-IDLE state restarts PRE and clears capture_done the next cycle.
  - start and trig_evt in the same cycle: start wins.
- RAM interface:
  - All RAM outputs are registered.
  - In PRE/ARMED/POST, en=we=1 and addr=wr_ptr for the 2-cycle adc period beginning at cap_tick, so rclk rises mid-window with addr stable. en=we=0 otherwise.
  - In IDLE/DONE: we=0, en=rd_en, addr=rd_addr, with 1-cycle latency. rd_en in other states is ignored.
- Width rules: wr_ptr is ADDR_W bits and wraps naturally. pre_cnt and post_cnt are ADDR_W+1 bits. trig_pos >= DEPTH is impossible by width.

Decomposition:
- Shared package: the cap_state_t enum (IDLE, PRE, ARMED, POST, DONE) and the DEPTH/ADDR_W constants.
- One sub-module: trig_detect (synchronizers, select, edge detect, force OR). Everything else stays in capture_ctrl.

Test Plan:
- Reset then idle: adc_clk toggles every cycle; en=we=0, armed=0, capture_done=0.
- dec_pwr=0, trig_pos=256, start: armed asserts after 256 cap_ticks. Rising trig1 then gives exactly 256 further writes, then capture_done=1 with oldest_addr = final wr_ptr.
- dec_pwr=2: cap_tick spacing is 8 clk cycles. The first write lands at addr 0, the next at addr 1.
- trig1 pulse during PRE is ignored. force_trig in ARMED with trig_pos=0 -> DONE after the current cycle, zero post writes.
- trig_sel=1, trig_edge=0: only a falling trig2 triggers; toggling trig1 has no effect.
- start during POST restarts PRE (armed=0, wr_ptr=0). rd_en=1, rd_addr=0x1A5 in DONE -> en=1, we=0, addr=0x1A5 one cycle later.

Source files
------------

// File: rtl/capture_ctrl_pkg.sv
// capture_ctrl_pkg: shared types and default sizes for the acquisition sequencer.
//   cap_state_t : capture state machine states
//   CAP_DEPTH   : sample RAM entries per channel
//   CAP_ADDR_W  : RAM address width (log2 CAP_DEPTH)
//   CAP_DEC_W   : width of the decimation exponent
package capture_ctrl_pkg;

    localparam int unsigned CAP_DEPTH  = 512;
    localparam int unsigned CAP_ADDR_W = 9;
    localparam int unsigned CAP_DEC_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl_trig.sv
// trig_detect: trigger qualification for the capture sequencer.
//   clk, rst     : system clock, synchronous active-high reset
//   trig1, trig2 : asynchronous AFE trigger pins
//   trig_sel     : 0 selects trig1, 1 selects trig2
//   trig_edge    : 1 = rising edge qualifies, 0 = falling edge qualifies
//   force_trig   : software trigger pulse, passed straight through
//   trig_evt     : one-cycle trigger event
module trig_detect (
    input  logic clk,
    input  logic rst,
    input  logic trig1,
    input  logic trig2,
    input  logic trig_sel,
    input  logic trig_edge,
    input  logic force_trig,
    output logic trig_evt
);

    logic [1:0] sync1;
    logic [1:0] sync2;
    logic       sel_s;
    logic       sel_d;
    logic       edge_evt;

    // Both pins are always synchronised so switching trig_sel never
    // exposes a metastable flop.
    always_comb begin
        sel_s = trig_sel ? sync2[1] : sync1[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sel_d    <= 1'b0;
            edge_evt <= 1'b0;
        end else begin
            sync1    <= {sync1[0], trig1};
            sync2    <= {sync2[0], trig2};
            sel_d    <= sel_s;
            edge_evt <= trig_edge ? (sel_s & ~sel_d) : (~sel_s & sel_d);
        end
    end

    // The software trigger bypasses the pipeline so it acts in the cycle it is issued.
    always_comb begin
        trig_evt = edge_evt | force_trig;
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: acquisition sequencer between the ADCs and the sample RAMs.
//   clk, rst        : 40 MHz system clock, synchronous active-high reset
//   start           : pulse, arm a new capture (restarts from any state)
//   force_trig      : pulse, software trigger
//   trig1, trig2    : asynchronous AFE triggers; trig_sel / trig_edge qualify them
//   trig_pos        : samples stored after the trigger
//   dec_pwr         : store one sample every 2^dec_pwr ADC samples
//   rd_en, rd_addr  : readout port, honoured in IDLE/DONE only
//   adc_clk, rclk   : clk/2 to the ADCs, RAM clock (~adc_clk)
//   en, we, addr    : registered RAM strobes
//   armed           : high in ARMED
//   capture_done    : high in DONE
//   oldest_addr     : RAM address of the oldest sample, valid with capture_done
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = CAP_DEPTH,
    parameter int unsigned ADDR_W = CAP_ADDR_W,
    parameter int unsigned DEC_W  = CAP_DEC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              force_trig,
    input  logic              trig1,
    input  logic              trig2,
    input  logic              trig_sel,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  dec_pwr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              adc_clk,
    output logic              rclk,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic              armed,
    output logic              capture_done,
    output logic [ADDR_W-1:0] oldest_addr
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    cap_state_t        state;
    logic [15:0]       dec_cnt;
    logic [15:0]       dec_lim;
    logic              smp;
    logic              cap_tick;
    logic              wr_tick;
    logic              wr_win;
    logic              trig_evt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W:0]   pre_cnt;
    logic [ADDR_W:0]   pre_cnt_nxt;
    logic [ADDR_W:0]   post_cnt;
    logic [ADDR_W:0]   post_cnt_nxt;
    logic [ADDR_W:0]   pre_target;

    trig_detect u_trig (
        .clk        (clk),
        .rst        (rst),
        .trig1      (trig1),
        .trig2      (trig2),
        .trig_sel   (trig_sel),
        .trig_edge  (trig_edge),
        .force_trig (force_trig),
        .trig_evt   (trig_evt)
    );

    // A write happens on a decimated sample tick while capturing; start
    // takes priority and discards the tick.
    always_comb begin
        smp          = ~adc_clk;
        dec_lim      = (16'd1 << dec_pwr) - 16'd1;
        cap_tick     = smp && (dec_cnt == dec_lim);
        wr_tick      = cap_tick && !start && (state inside {PRE, ARMED, POST});
        wr_ptr_nxt   = wr_ptr + {{(ADDR_W-1){1'b0}}, wr_tick};
        pre_cnt_nxt  = pre_cnt + {{ADDR_W{1'b0}}, wr_tick};
        post_cnt_nxt = post_cnt + {{ADDR_W{1'b0}}, wr_tick};
        pre_target   = DEPTH_CNT - {1'b0, trig_pos};
    end

    // ADC / RAM clocks and the decimation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_clk <= 1'b0;
            rclk    <= 1'b1;
            dec_cnt <= '0;
        end else begin
            adc_clk <= ~adc_clk;
            rclk    <= adc_clk;
            if (start || cap_tick) begin
                dec_cnt <= '0;
            end else if (smp) begin
                dec_cnt <= dec_cnt + 16'd1;
            end
        end
    end

    // Capture state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
            oldest_addr  <= '0;
        end else if (start) begin
            state        <= PRE;
            wr_ptr       <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            armed        <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            case (state)
                IDLE: begin
                end
                PRE: begin
                    pre_cnt <= pre_cnt_nxt;
                    if (pre_cnt_nxt == pre_target) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (trig_evt) begin
                        armed <= 1'b0;
                        if (trig_pos == '0) begin
                            state        <= DONE;
                            capture_done <= 1'b1;
                            oldest_addr  <= wr_ptr_nxt;
                        end else begin
                            state <= POST;
                        end
                    end
                end
                POST: begin
                    post_cnt <= post_cnt_nxt;
                    if (post_cnt_nxt == {1'b0, trig_pos}) begin
                        state        <= DONE;
                        capture_done <= 1'b1;
                        oldest_addr  <= wr_ptr_nxt;
                    end
                end
                DONE: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM strobes. A write window spans the full adc period after the tick
    // (wr_win marks its second half) and may run into DONE after the last
    // post-trigger write, so it takes precedence over the readout path.
    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= 1'b0;
            we     <= 1'b0;
            addr   <= '0;
            wr_win <= 1'b0;
        end else if (wr_tick) begin
            en     <= 1'b1;
            we     <= 1'b1;
            addr   <= wr_ptr;
            wr_win <= 1'b1;
        end else if (wr_win) begin
            wr_win <= 1'b0;
        end else if (state == IDLE || state == DONE) begin
            en   <= rd_en;
            we   <= 1'b0;
            addr <= rd_addr;
        end else begin
            en <= 1'b0;
            we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: randomized scoreboard bench for capture_ctrl.
// The stimulus process decides how many writes each capture should make and
// queues the expected RAM addresses; the monitor pops one entry per observed
// write window and checks address, window shape, spacing and armed.
module tb_capture_ctrl;

    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst, start, force_trig, trig1, trig2, trig_sel, trig_edge;
    logic [8:0] trig_pos, rd_addr;
    logic [3:0] dec_pwr;
    logic       rd_en;
    logic       adc_clk, rclk, en, we, armed, capture_done;
    logic [8:0] addr, oldest_addr;

    capture_ctrl #(.DEPTH(512), .ADDR_W(9), .DEC_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .force_trig   (force_trig),
        .trig1        (trig1),
        .trig2        (trig2),
        .trig_sel     (trig_sel),
        .trig_edge    (trig_edge),
        .trig_pos     (trig_pos),
        .dec_pwr      (dec_pwr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .adc_clk      (adc_clk),
        .rclk         (rclk),
        .en           (en),
        .we           (we),
        .addr         (addr),
        .armed        (armed),
        .capture_done (capture_done),
        .oldest_addr  (oldest_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned exp_q[$];
    int wr_seen = 0;     // written only by the monitor
    int cyc     = 0;     // written only by the monitor
    int base    = 0;     // write count at the current capture's start
    int target  = 0;     // pre-trigger writes before armed
    bit pre_phase = 1'b0;
    bit capturing = 1'b0;
    bit in_reset  = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        bit          in_win;
        int unsigned cur;
        int          last_start;
        bit          prev_adc;
        in_win = 1'b0;
        cur = 0;
        last_start = 0;
        prev_adc = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_reset) begin
                in_win   = 1'b0;
                prev_adc = adc_clk;
                continue;
            end
            chk("adc_toggle", adc_clk, !prev_adc);
            chk("rclk_inv", rclk, !adc_clk);
            prev_adc = adc_clk;
            if (capturing) chk("en_eq_we", en, we);
            if (we && !in_win) begin
                in_win = 1'b1;
                wr_seen++;
                chk("rclk_win_lo", rclk, 0);
                chk("exp_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", addr, cur);
                end
                if (wr_seen - base >= 2) chk("wr_gap", cyc - last_start, 2 << dec_pwr);
                last_start = cyc;
                chk("armed", armed, pre_phase && (wr_seen - base >= target));
            end else if (we && in_win) begin
                in_win = 1'b0;
                chk("wr_addr_hold", addr, cur);
                chk("rclk_win_hi", rclk, 1);
            end else begin
                in_win = 1'b0;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Returns in the first cycle of the n-th write window.
    task automatic wait_writes(input int n, output bit ok);
        int guard;
        guard = 0;
        ok = 1'b1;
        while (wr_seen < n) begin
            tick_n(1);
            guard++;
            if (guard > 40000) begin
                chk("timeout_writes", wr_seen, n);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic begin_cap(input int n);
        start     = 1'b1;
        base      = wr_seen;
        pre_phase = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(k % DEPTH);
        tick_n(1);
        start = 1'b0;
        tick_n(1);
        capturing = 1'b1;
    endtask

    // mode 0: force_trig; 1: trig1 rising, with a trig1 pulse during PRE;
    // 2: trig2 falling, with trig1 noise while armed; 3: force_trig, then
    // start during POST and a full force-triggered capture.
    task automatic run_capture(input int dp, input int tp, input int extra,
                               input int mode, output bit ok);
        int w;
        int guard;
        int ra;
        ok        = 1'b1;
        dec_pwr   = 4'(dp);
        trig_pos  = 9'(tp);
        trig_sel  = (mode == 2);
        trig_edge = (mode != 2);
        trig1     = 1'b0;
        trig2     = (mode == 2);
        rd_en     = 1'b1;
        rd_addr   = 9'($urandom_range(0, 511));
        tick_n(6);
        target = DEPTH - tp;
        w      = target + extra;
        begin_cap(w + ((mode == 3) ? 5 : tp));
        if (mode == 3) begin
            wait_writes(base + w, ok);
            if (!ok) return;
            force_trig = 1'b1;
            pre_phase  = 1'b0;
            tick_n(1);
            force_trig = 1'b0;
            wait_writes(base + w + 5, ok);
            if (!ok) return;
            begin_cap(w + tp);
        end
        if (mode == 1) begin
            wait_writes(base + 10, ok);
            if (!ok) return;
            trig1 = 1'b1;
            tick_n(4);
            trig1 = 1'b0;
        end
        if (mode == 2) begin
            wait_writes(base + target + 2, ok);
            if (!ok) return;
            trig1 = 1'b1;
            tick_n(3);
            trig1 = 1'b0;
        end
        wait_writes(base + w, ok);
        if (!ok) return;
        case (mode)
            1:       trig1 = 1'b1;
            2:       trig2 = 1'b0;
            default: force_trig = 1'b1;
        endcase
        pre_phase = 1'b0;
        tick_n(1);
        force_trig = 1'b0;
        guard = 0;
        while (!capture_done) begin
            tick_n(1);
            guard++;
            if (guard > 40000) begin
                chk("timeout_done", capture_done, 1);
                ok = 1'b0;
                return;
            end
        end
        capturing = 1'b0;
        chk("done_writes", wr_seen - base, w + tp);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("oldest_addr", oldest_addr, (w + tp) % DEPTH);
        chk("armed_in_done", armed, 0);
        tick_n(4);
        chk("done_hold", capture_done, 1);
        rd_en = 1'b0;
        tick_n(1);
        chk("rd_off_en", en, 0);
        ra      = (mode == 3) ? 'h1A5 : int'($urandom_range(0, 511));
        rd_en   = 1'b1;
        rd_addr = 9'(ra);
        tick_n(1);
        chk("rd_en", en, 1);
        chk("rd_we", we, 0);
        chk("rd_addr", addr, ra);
        rd_en = 1'b0;
        trig1 = 1'b0;
        trig2 = 1'b0;
        tick_n(2);
    endtask

    initial begin : stim
        bit ok;
        rst = 1'b1; start = 1'b0; force_trig = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
        trig_sel = 1'b0; trig_edge = 1'b1; trig_pos = '0; dec_pwr = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        tick_n(1);
        chk("rst_adc_clk", adc_clk, 0);
        chk("rst_rclk", rclk, 1);
        chk("rst_en", en, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_oldest", oldest_addr, 0);
        rst = 1'b0;
        in_reset = 1'b0;
        tick_n(8);
        chk("idle_en", en, 0);
        chk("idle_we", we, 0);
        chk("idle_armed", armed, 0);
        chk("idle_done", capture_done, 0);
        run_capture(0, 256, 5, 0, ok);
        if (ok) run_capture(2, 100, int'($urandom_range(1, 12)), 1, ok);
        if (ok) run_capture(0, 0, int'($urandom_range(1, 8)), 0, ok);
        if (ok) run_capture(2, 50, int'($urandom_range(4, 12)), 2, ok);
        if (ok) run_capture(1, 200, int'($urandom_range(1, 10)), 3, ok);
        if (ok) run_capture(3, int'($urandom_range(1, 300)), int'($urandom_range(1, 10)), 0, ok);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
